tl_controller: RTL and testbench
================================

// Module: tl_controller
// PURPOSE
//  Two-road traffic-light controller (Moore FSM) for an intersection of street A and street B.
//  Ta/Tb are traffic-sensor inputs; La/Lb drive the light heads of each street.
//  Green is held on a street while its sensor reports traffic; otherwise the light steps through yellow to red.
//  Standalone leaf block: one clock domain, no handshakes.
// PARAMETERS
//  YELLOW_CYCLES  1  clock cycles each yellow phase lasts (>=1); at 1 yellow occupies exactly one cycle
// PORTS
//  clk    in   1  rising-edge clock; single clock domain
//  reset  in   1  asynchronous, active-high; forces state S0 immediately
//  Ta     in   1  1 = traffic present on street A
//  Tb     in   1  1 = traffic present on street B
//  La     out  2  street A light: 2'b00 green, 2'b01 yellow, 2'b10 red (2'b11 never driven)
//  Lb     out  2  street B light, same encoding
// BEHAVIOUR
//  - Four states, 2-bit state register: S0 A-green, S1 A-yellow, S2 B-green, S3 B-yellow.
//  - Outputs decode combinationally from the state register only (Moore); no input-to-output path.
//  - State outputs:
//    - S0: La=00, Lb=10
//    - S1: La=01, Lb=10
//    - S2: La=10, Lb=00
//    - S3: La=10, Lb=01
//  - Transitions are sampled on the rising clk edge:
//    - S0: Ta=1 -> S0; Ta=0 -> S1.
//    - S1: yellow counter reaches YELLOW_CYCLES-1 -> S2; otherwise stay in S1. Ta/Tb are ignored.
//    - S2: Tb=1 -> S2; Tb=0 -> S3.
//    - S3: yellow counter reaches YELLOW_CYCLES-1 -> S0; otherwise stay in S3. Ta/Tb are ignored.
//  - Yellow counter:
//    - width $clog2(YELLOW_CYCLES+1).
//    - Cleared on every entry to S1/S3 and whenever the state is not S1/S3.
//    - Increments each cycle spent in yellow.
//  - Latency: a sensor change sampled at edge k changes the lights right after edge k.
//  - Reset value: state S0, counter 0, so La=00 (green) and Lb=10 (red).
//    - Takes effect asynchronously, including mid-yellow.
//    - Held while reset=1 regardless of Ta/Tb.
//  - Release of reset is synchronous in effect: the first transition happens on the first rising edge with reset=0.
//  - Ta and Tb are both 1: the street currently green keeps green indefinitely (no forced change).
//  - Ta and Tb are both 0: the FSM cycles S0->S1->S2->S3->S0 continuously.
//  - Safety invariant: La and Lb are never both non-red; exactly one street is red in every state.
//  - Illegal/unreachable state encodings do not exist (4 of 4 used); the default branch goes to S0.
// TESTING
//  1. Apply reset=1 with Ta/Tb toggling for 4 cycles -> La=00, Lb=10 throughout.
//     Assert reset mid-S1 -> outputs return to 00/10 immediately.
//  2. Release reset with Ta=1, Tb=x -> stays in S0 (La=00, Lb=10) every cycle while Ta=1.
//  3. From S0 drive Ta=0, Tb=1 -> S1 (01/10) for one cycle, then S2 (10/00), held while Tb=1.
//  4. In S2 drive Tb=0, Ta=1 -> S3 (10/01) for one cycle, then S0 (00/10).
//  5. Ta=Tb=0 for 8 cycles -> periodic 00/10, 01/10, 10/00, 10/01 with period 4.
//     With YELLOW_CYCLES=3 -> period 8.
//  6. Random Ta/Tb over 1000 cycles -> assert La/Lb never both non-red, and neither output is ever 2'b11.

Source files
------------

// File: rtl/tl_controller.sv
// rtl/tl_controller.sv - two-road traffic-light Moore FSM with programmable yellow length
module tl_controller #(
  parameter int YELLOW_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Ta,
  input  logic       Tb,
  output logic [1:0] La,
  output logic [1:0] Lb
);

  localparam int CW = $clog2(YELLOW_CYCLES + 1);
  localparam logic [CW-1:0] YLAST = CW'(YELLOW_CYCLES - 1);

  localparam logic [1:0] GREEN  = 2'b00;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b10;

  typedef enum logic [1:0] {
    S0 = 2'd0,  // A green
    S1 = 2'd1,  // A yellow
    S2 = 2'd2,  // B green
    S3 = 2'd3   // B yellow
  } state_t;

  state_t        state_q;
  logic [CW-1:0] ycnt_q;

  // State and yellow counter; the counter only runs while a yellow phase is showing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S0;
      ycnt_q  <= '0;
    end else begin
      case (state_q)
        S0: begin
          ycnt_q <= '0;
          if (!Ta) state_q <= S1;
        end
        S1: begin
          if (ycnt_q == YLAST) begin
            state_q <= S2;
            ycnt_q  <= '0;
          end else begin
            ycnt_q  <= ycnt_q + 1'b1;
          end
        end
        S2: begin
          ycnt_q <= '0;
          if (!Tb) state_q <= S3;
        end
        S3: begin
          if (ycnt_q == YLAST) begin
            state_q <= S0;
            ycnt_q  <= '0;
          end else begin
            ycnt_q  <= ycnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= S0;
          ycnt_q  <= '0;
        end
      endcase
    end
  end

  // Light heads decode from the state register alone, so sensors never reach the lamps directly
  always_comb begin
    La = RED;
    Lb = RED;
    case (state_q)
      S0: begin La = GREEN;  Lb = RED;    end
      S1: begin La = YELLOW; Lb = RED;    end
      S2: begin La = RED;    Lb = GREEN;  end
      S3: begin La = RED;    Lb = YELLOW; end
      default: begin La = GREEN; Lb = RED; end
    endcase
  end

endmodule

// File: tb/tb_tl_controller.sv
// tb/tb_tl_controller.sv - randomized model-based bench for tl_controller (yellow 1 and 3)
module tb_tl_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       Ta, Tb;
  logic [1:0] La1, Lb1, La3, Lb3;

  int checks = 0;
  int errors = 0;

  // Reference model: which street is green, whether it is currently showing yellow,
  // and how many yellow cycles remain. Index 0 = yellow length 1, index 1 = length 3.
  int ycyc[2] = '{1, 3};
  bit m_green_b[2];
  bit m_yel[2];
  int m_left[2];

  always #5 clk = ~clk;

  tl_controller #(.YELLOW_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .Ta(Ta), .Tb(Tb), .La(La1), .Lb(Lb1)
  );

  tl_controller #(.YELLOW_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .Ta(Ta), .Tb(Tb), .La(La3), .Lb(Lb3)
  );

  function automatic logic [1:0] exp_light(int u, bit street_b);
    if (m_green_b[u] == street_b) return m_yel[u] ? 2'b01 : 2'b00;
    return 2'b10;
  endfunction

  function automatic logic [3:0] got_lights(int u);
    return (u == 0) ? {La1, Lb1} : {La3, Lb3};
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_green_b[u] = 1'b0;
      m_yel[u]     = 1'b0;
      m_left[u]    = 0;
    end
  endtask

  task automatic model_step(input bit ta, input bit tb);
    for (int u = 0; u < 2; u++) begin
      if (!m_yel[u]) begin
        if ((m_green_b[u] ? tb : ta) == 1'b0) begin
          m_yel[u]  = 1'b1;
          m_left[u] = ycyc[u];
        end
      end else begin
        m_left[u] = m_left[u] - 1;
        if (m_left[u] == 0) begin
          m_yel[u]     = 1'b0;
          m_green_b[u] = ~m_green_b[u];
        end
      end
    end
  endtask

  task automatic tick(input bit ta, input bit tb);
    Ta = ta;
    Tb = tb;
    @(posedge clk);
    if (!reset) model_step(ta, tb);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    Ta = 1'b0;
    Tb = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      tick(1'($urandom), 1'($urandom));
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (got_lights(u) !== 4'b0010) begin
          errors++;
          $display("FAIL reset_hold u=%0d cyc=%0d got=%b want=0010", u, c, got_lights(u));
        end
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_hold_a();
    for (int c = 0; c < 5; c++) begin
      tick(1'b1, 1'($urandom));
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (got_lights(u) !== 4'b0010 || got_lights(u) !== {exp_light(u, 0), exp_light(u, 1)}) begin
          errors++;
          $display("FAIL hold_a u=%0d cyc=%0d got=%b want=0010", u, c, got_lights(u));
        end
      end
    end
  endtask

  task automatic test_a_to_b();
    for (int c = 0; c < 6; c++) begin
      tick((c == 0) ? 1'b0 : 1'($urandom), 1'b1);
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (got_lights(u) !== {exp_light(u, 0), exp_light(u, 1)}) begin
          errors++;
          $display("FAIL a_to_b u=%0d cyc=%0d got=%b want=%b", u, c, got_lights(u),
                   {exp_light(u, 0), exp_light(u, 1)});
        end
      end
      if (c == 0) begin
        checks++;
        if ({La1, Lb1} !== 4'b0110) begin
          errors++;
          $display("FAIL a_yellow_one_cycle got=%b want=0110", {La1, Lb1});
        end
      end
      if (c == 1) begin
        checks++;
        if ({La1, Lb1} !== 4'b1000) begin
          errors++;
          $display("FAIL b_green_entry got=%b want=1000", {La1, Lb1});
        end
      end
    end
  endtask

  task automatic test_b_to_a();
    for (int c = 0; c < 6; c++) begin
      tick(1'b1, (c == 0) ? 1'b0 : 1'($urandom));
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (got_lights(u) !== {exp_light(u, 0), exp_light(u, 1)}) begin
          errors++;
          $display("FAIL b_to_a u=%0d cyc=%0d got=%b want=%b", u, c, got_lights(u),
                   {exp_light(u, 0), exp_light(u, 1)});
        end
      end
      if (c == 0) begin
        checks++;
        if ({La1, Lb1} !== 4'b1001) begin
          errors++;
          $display("FAIL b_yellow_one_cycle got=%b want=1001", {La1, Lb1});
        end
      end
      if (c == 1) begin
        checks++;
        if ({La1, Lb1} !== 4'b0010) begin
          errors++;
          $display("FAIL a_green_return got=%b want=0010", {La1, Lb1});
        end
      end
    end
  endtask

  task automatic test_cycle();
    logic [3:0] h1[16];
    logic [3:0] h3[16];
    for (int c = 0; c < 16; c++) begin
      tick(1'b0, 1'b0);
      h1[c] = {La1, Lb1};
      h3[c] = {La3, Lb3};
      for (int u = 0; u < 2; u++) begin
        checks++;
        if (got_lights(u) !== {exp_light(u, 0), exp_light(u, 1)}) begin
          errors++;
          $display("FAIL cycle u=%0d cyc=%0d got=%b want=%b", u, c, got_lights(u),
                   {exp_light(u, 0), exp_light(u, 1)});
        end
      end
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (h1[i] !== h1[i+4]) begin
        errors++;
        $display("FAIL period4 i=%0d got=%b want=%b", i, h1[i+4], h1[i]);
      end
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (h3[i] !== h3[i+8]) begin
        errors++;
        $display("FAIL period8 i=%0d got=%b want=%b", i, h3[i+8], h3[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    checks++;
    if ({La3, Lb3} !== 4'b0110 || {La3, Lb3} !== {exp_light(1, 0), exp_light(1, 1)}) begin
      errors++;
      $display("FAIL pre_reset_yellow got=%b want=0110", {La3, Lb3});
    end
    #1 reset = 1'b1;
    #1;
    model_reset();
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (got_lights(u) !== 4'b0010) begin
        errors++;
        $display("FAIL async_reset u=%0d got=%b want=0010", u, got_lights(u));
      end
    end
    tick(1'b0, 1'b0);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (got_lights(u) !== 4'b0010) begin
        errors++;
        $display("FAIL reset_held u=%0d got=%b want=0010", u, got_lights(u));
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [1:0] la, lb;
    for (int c = 0; c < 1000; c++) begin
      tick(1'($urandom), 1'($urandom));
      for (int u = 0; u < 2; u++) begin
        la = got_lights(u)[3:2];
        lb = got_lights(u)[1:0];
        checks++;
        if ({la, lb} !== {exp_light(u, 0), exp_light(u, 1)}) begin
          errors++;
          $display("FAIL random_model u=%0d cyc=%0d got=%b want=%b", u, c, {la, lb},
                   {exp_light(u, 0), exp_light(u, 1)});
        end
        checks++;
        if (la === 2'b11 || lb === 2'b11 || !((la === 2'b10) ^ (lb === 2'b10))) begin
          errors++;
          $display("FAIL safety u=%0d cyc=%0d got La=%b Lb=%b want exactly one red", u, c, la, lb);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    Ta = 1'b0;
    Tb = 1'b0;
    test_reset();
    test_hold_a();
    test_a_to_b();
    test_b_to_a();
    test_cycle();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
